// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake and read-port bundle for the iterative AES-128 key-schedule controller.
//   start     : request expansion of key_in (taken only while the controller is idle)
//   key_in    : 128-bit cipher key, key_in[127:96] = w[0]
//   busy      : expansion in progress
//   done      : one-cycle pulse once every round key is in the bank
//   keys_ok   : bank holds a complete schedule for the last accepted key
//   rd_round  : round-key index to read
//   rd_key    : registered round key for rd_round (one-cycle latency)
// master = requester / round datapath, slave = key-schedule controller.
interface aes_key_sched_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_ok;
  logic [3:0]   rd_round;
  logic [127:0] rd_key;

  modport master (
    output start, key_in, rd_round,
    input  busy, done, keys_ok, rd_key
  );

  modport slave (
    input  start, key_in, rd_round,
    output busy, done, keys_ok, rd_key
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Expands one 128-bit cipher key into NUM_ROUNDS+1 round keys, reusing SBOX_LANES
// S-box instances for SubWord, and keeps the schedule in a register bank that the
// round datapath reads by index.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (aborts any expansion, clears the bank)
//   bus  : aes_key_sched_ctrl_if.slave (start/key_in request, busy/done/keys_ok
//          status, rd_round/rd_key registered read port)
module aes_key_sched_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int SBOX_LANES = 4
) (
  input logic                 clk,
  input logic                 rst,
  aes_key_sched_ctrl_if.slave bus
);

  localparam int         SUB_CYC    = 4 / SBOX_LANES;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [1:0] LAST_LANE  = 2'(SUB_CYC - 1);

  typedef enum logic [1:0] {IDLE, SUB, EXP, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] rk [0:NUM_ROUNDS];
  logic [127:0] cur;
  logic [31:0]  tmp;
  logic [7:0]   rcon;
  logic [3:0]   round;
  logic [1:0]   lane;
  logic         keys_ok;
  logic [127:0] rd_key;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    inv  = gf_mul(a252, a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round counter codes outside 1..NUM_ROUNDS can only come from corruption.
  logic round_bad;
  logic lane_last;
  assign round_bad = (round == 4'd0) || (round > LAST_ROUND);
  assign lane_last = (lane == LAST_LANE);

  // SubWord lanes: lane k of sub-cycle `lane` handles byte lane*SBOX_LANES+k,
  // byte 0 being the MSB of RotWord(cur[31:0]).
  logic [31:0] rot;
  logic [1:0]  bsel   [SBOX_LANES];
  logic [7:0]  sb_in  [SBOX_LANES];
  logic [7:0]  sb_out [SBOX_LANES];
  assign rot = {cur[23:0], cur[31:24]};

  always_comb begin
    for (int k = 0; k < SBOX_LANES; k++) begin
      bsel[k]   = 2'(int'(lane) * SBOX_LANES + k);
      sb_in[k]  = rot[{~bsel[k], 3'b000} +: 8];
      sb_out[k] = sbox(sb_in[k]);
    end
  end

  // Next round key from the previous one and the substituted word.
  logic [31:0]  g, n0, n1, n2, n3;
  logic [127:0] nk;
  assign g  = tmp ^ {rcon, 24'h000000};
  assign n0 = cur[127:96] ^ g;
  assign n1 = cur[95:64]  ^ n0;
  assign n2 = cur[63:32]  ^ n1;
  assign n3 = cur[31:0]   ^ n2;
  assign nk = {n0, n1, n2, n3};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = SUB;
      SUB: begin
        if (round_bad)      state_nxt = IDLE;
        else if (lane_last) state_nxt = EXP;
      end
      EXP: begin
        if (round_bad)                 state_nxt = IDLE;
        else if (round == LAST_ROUND)  state_nxt = DONE;
        else                           state_nxt = SUB;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy    = (state == SUB) || (state == EXP);
    bus.done    = (state == DONE);
    bus.keys_ok = keys_ok;
    bus.rd_key  = rd_key;
  end

  // Datapath and bank; the read is registered every cycle and sees the
  // pre-write value of an entry written on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r <= NUM_ROUNDS; r++) rk[r] <= '0;
      cur     <= '0;
      tmp     <= '0;
      rcon    <= 8'h01;
      round   <= 4'd0;
      lane    <= 2'd0;
      keys_ok <= 1'b0;
      rd_key  <= '0;
    end else begin
      rd_key <= (bus.rd_round <= LAST_ROUND) ? rk[bus.rd_round] : '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rk[0]   <= bus.key_in;
            cur     <= bus.key_in;
            rcon    <= 8'h01;
            round   <= 4'd1;
            lane    <= 2'd0;
            keys_ok <= 1'b0;
          end
        end
        SUB: begin
          for (int k = 0; k < SBOX_LANES; k++) tmp[{~bsel[k], 3'b000} +: 8] <= sb_out[k];
          lane <= lane_last ? 2'd0 : lane + 2'd1;
        end
        EXP: begin
          if (!round_bad) begin
            rk[round] <= nk;
            cur       <= nk;
            rcon      <= xtime(rcon);
            if (round == LAST_ROUND) keys_ok <= 1'b1;
            else                     round   <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
